display_scan_scheduler: RTL and testbench
=========================================

// Module: display_scan_scheduler
// PURPOSE
//  Sequencer and source arbiter for the 4-digit 7-segment display path.
//  - Generates the byte_status scan index and the per-digit enable mask
//    (segment_byte_control) consumed by the segment driver.
//  - Selects data_show between the running-time source and an overlay source
//    (alarm/settings) and updates it only at frame boundaries (no tearing).
//  - Applies per-digit blinking.
// PARAMETERS
//  SCAN_DIV      1000  clock cycles per byte_status step (>=2)
//  BLINK_DIV     64    scan frames per blink half-period (>=1)
//  OVERLAY_HOLD  256   frames overlay stays selected after ovl_req drops (>=1)
// PORTS
//  clock                 in   1   system clock
//  reset                 in   1   asynchronous, active-low reset
//  enable                in   1   1 = scan running; 0 = display blanked
//  time_data             in   12  time source: [11:6] high pair, [5:0] low pair
//  ovl_data              in   12  overlay source, same packing
//  ovl_req               in   1   level request for overlay display
//  blink_mask            in   4   bit i = digit i blinks
//  digit_enable          in   4   bit i = digit i may light
//  data_show             out  12  registered value to display
//  byte_status           out  3   scan slot: 0/2/4/6 = digit 0..3, odd = blank gap
//  segment_byte_control  out  4   bit i = 1 -> digit i lit when its slot is active
//  frame_tick            out  1   1-cycle pulse on each frame boundary
//  ovl_ack               out  1   1-cycle pulse when the overlay is granted
//  ovl_active            out  1   overlay currently selected
// BEHAVIOUR
//  Reset values: byte_status=7, data_show=0, segment_byte_control=0,
//    frame_tick=0, ovl_ack=0, ovl_active=0; internal counters and blink_phase=0.
//  Prescaler: counts 0..SCAN_DIV-1 while enable=1.
//    - step = (count==SCAN_DIV-1); count wraps to 0.
//    - On step, byte_status <= byte_status+1 (mod 8).
//  Frame boundary = step while byte_status==7 (7->0 transition). In that cycle:
//    - frame_tick=1.
//    - data_show latched from the source selected after this boundary's
//      arbitration decision; mid-frame input changes are ignored.
//    - segment_byte_control <= digit_enable & ~(blink_mask & {4{blink_phase_next}}).
//  Blink: frame counter 0..BLINK_DIV-1; blink_phase toggles on wrap.
//  Arbiter FSM (evaluated only at frame boundaries):
//    - SRC_TIME: ovl_req=1 -> SRC_OVL; ovl_ack pulses that cycle;
//      hold <= OVERLAY_HOLD; ovl_data latched in the same boundary.
//    - SRC_OVL: ovl_req=1 -> hold <= OVERLAY_HOLD; ovl_req=0 -> hold-1;
//      hold reaching 0 -> SRC_TIME, time_data latched in the same boundary.
//    - ovl_active = (state==SRC_OVL), registered.
//    - ovl_req change coincident with a boundary is sampled (counts).
//  enable=0:
//    - Next cycle: prescaler=0, byte_status=7 (blank), no frame_tick.
//    - Arbiter/blink frozen; data_show held.
//    - Re-enable: first step after SCAN_DIV cycles is a frame boundary.
//  Reset asserted mid-operation: all state returns to reset values immediately
//    (async); release is synchronised by the reset tree upstream.
//  Width rules:
//    - Prescaler $clog2(SCAN_DIV) bits; hold and frame counters sized from
//      their parameters.
//    - data_show is a pass-through: no range check of values >59.
// STRUCTURE
//  Shared package display_pkg:
//    - Slot constants SLOT_D0=0, SLOT_D1=2, SLOT_D2=4, SLOT_D3=6, SLOT_BLANK=7.
//    - Arbiter state encoding SRC_TIME/SRC_OVL.
//    - Width constants: DATA_W=12, DIGITS=4.
//  Sub-module tick_divider (parameter DIV; ports clock, reset, clr, en, tick),
//    instanced for the scan prescaler. Arbiter, blink logic and output
//    registers stay in this module.
// TESTING  (SCAN_DIV=4, BLINK_DIV=2, OVERLAY_HOLD=3)
//  1. Reset release, enable=1 -> byte_status 7->0 after 4 clocks, then 1..7
//     every 4 clocks; frame_tick every 32 clocks.
//  2. time_data=12'h2CB set at byte_status=3 -> data_show stays old until
//     7->0, then 12'h2CB.
//  3. ovl_req=1, ovl_data=12'h105 -> at next boundary: ovl_ack single pulse,
//     ovl_active=1, data_show=12'h105. ovl_req=0 -> time_data returns
//     exactly 3 boundaries later.
//  4. digit_enable=4'hF, blink_mask=4'b0011 -> segment_byte_control
//     alternates 4'hF / 4'hC every 2 frames.
//  5. enable=0 at byte_status=3 -> next clock byte_status=7, no frame_tick.
//     enable=1 -> byte_status=0 with frame_tick after 4 clocks.
//  6. reset=0 while ovl_active=1 -> all outputs at reset values in the same
//     cycle, without waiting for a clock edge.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants and types for the 4-digit 7-segment display path.
package display_pkg;

    localparam int DATA_W = 12;
    localparam int DIGITS = 4;

    // Scan slots: even slots light a digit, odd slots are blank gaps.
    localparam logic [2:0] SLOT_D0    = 3'd0;
    localparam logic [2:0] SLOT_D1    = 3'd2;
    localparam logic [2:0] SLOT_D2    = 3'd4;
    localparam logic [2:0] SLOT_D3    = 3'd6;
    localparam logic [2:0] SLOT_BLANK = 3'd7;

    typedef enum logic {
        SRC_TIME = 1'b0,
        SRC_OVL  = 1'b1
    } src_state_t;

endpackage

// File: rtl/tick_divider.sv
// Free-running modulo-DIV counter; tick is high in the last cycle of each period.
module tick_divider #(
    parameter int DIV = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] count;

    assign tick = en && (count == CW'(DIV - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/display_scan_scheduler.sv
// Scan sequencer, blink generator and time/overlay source arbiter for the
// 4-digit display; displayed data and digit mask only change at frame boundaries.
module display_scan_scheduler
    import display_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_DIV    = 64,
    parameter int OVERLAY_HOLD = 256
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] time_data,
    input  logic [DATA_W-1:0] ovl_data,
    input  logic              ovl_req,
    input  logic [DIGITS-1:0] blink_mask,
    input  logic [DIGITS-1:0] digit_enable,
    output logic [DATA_W-1:0] data_show,
    output logic [2:0]        byte_status,
    output logic [DIGITS-1:0] segment_byte_control,
    output logic              frame_tick,
    output logic              ovl_ack,
    output logic              ovl_active
);

    localparam int FCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int HW  = $clog2(OVERLAY_HOLD + 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(OVERLAY_HOLD);

    src_state_t     state;
    logic [HW-1:0]  hold;
    logic [FCW-1:0] frame_cnt;
    logic           blink_phase;
    logic           step;
    logic           frame_edge;
    logic           frame_wrap;
    logic           phase_next;

    // Disabling clears the prescaler so re-enable waits a full SCAN_DIV period.
    tick_divider #(.DIV(SCAN_DIV)) u_prescaler (
        .clock (clock),
        .reset (reset),
        .clr   (!enable),
        .en    (enable),
        .tick  (step)
    );

    assign frame_edge = step && (byte_status == SLOT_BLANK);
    assign frame_wrap = (frame_cnt == FCW'(BLINK_DIV - 1));
    assign phase_next = frame_wrap ? !blink_phase : blink_phase;

    // Handshake: ovl_req is a level request sampled only at frame boundaries;
    // ovl_ack pulses for one cycle in the boundary that grants the overlay and
    // ovl_active stays high for as long as the overlay source is selected.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            byte_status          <= SLOT_BLANK;
            data_show            <= '0;
            segment_byte_control <= '0;
            frame_tick           <= 1'b0;
            ovl_ack              <= 1'b0;
            ovl_active           <= 1'b0;
            state                <= SRC_TIME;
            hold                 <= '0;
            frame_cnt            <= '0;
            blink_phase          <= 1'b0;
        end else begin
            frame_tick <= frame_edge;
            ovl_ack    <= 1'b0;

            if (!enable) begin
                byte_status <= SLOT_BLANK;
            end else if (step) begin
                byte_status <= byte_status + 3'd1;
            end

            if (frame_edge) begin
                frame_cnt            <= frame_wrap ? '0 : frame_cnt + FCW'(1);
                blink_phase          <= phase_next;
                segment_byte_control <= digit_enable & ~(blink_mask & {DIGITS{phase_next}});

                case (state)
                    SRC_TIME: begin
                        if (ovl_req) begin
                            state      <= SRC_OVL;
                            ovl_active <= 1'b1;
                            ovl_ack    <= 1'b1;
                            hold       <= HOLD_INIT;
                            data_show  <= ovl_data;
                        end else begin
                            data_show  <= time_data;
                        end
                    end
                    SRC_OVL: begin
                        if (ovl_req) begin
                            hold      <= HOLD_INIT;
                            data_show <= ovl_data;
                        end else if (hold <= HW'(1)) begin
                            // Last held frame expired: hand back to the clock source.
                            state      <= SRC_TIME;
                            ovl_active <= 1'b0;
                            hold       <= '0;
                            data_show  <= time_data;
                        end else begin
                            hold      <= hold - HW'(1);
                            data_show <= ovl_data;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Randomised scoreboard bench for display_scan_scheduler with directed checks
// of scan timing, tear-free updates, overlay hold, blinking, blanking and reset.
module tb_display_scan_scheduler;

    localparam int SD    = 4;
    localparam int BD    = 2;
    localparam int OH    = 3;
    localparam int EXP_W = 18;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [11:0] time_data = '0;
    logic [11:0] ovl_data = '0;
    logic        ovl_req = 1'b0;
    logic [3:0]  blink_mask = '0;
    logic [3:0]  digit_enable = 4'hF;
    logic [11:0] data_show;
    logic [2:0]  byte_status;
    logic [3:0]  segment_byte_control;
    logic        frame_tick;
    logic        ovl_ack;
    logic        ovl_active;

    display_scan_scheduler #(
        .SCAN_DIV     (SD),
        .BLINK_DIV    (BD),
        .OVERLAY_HOLD (OH)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .enable               (enable),
        .time_data            (time_data),
        .ovl_data             (ovl_data),
        .ovl_req              (ovl_req),
        .blink_mask           (blink_mask),
        .digit_enable         (digit_enable),
        .data_show            (data_show),
        .byte_status          (byte_status),
        .segment_byte_control (segment_byte_control),
        .frame_tick           (frame_tick),
        .ovl_ack              (ovl_ack),
        .ovl_active           (ovl_active)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- counters and check helper ----------------
    int vectors = 0;
    int miscompares = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    // Scan position is derived from the number of enabled clocks since the last
    // blank/reset; the overlay is shown while ovl_req was seen at any of the
    // last OH frame boundaries.
    int             en_cycles = 0;
    int             frames_seen = 0;
    logic [2:0]     exp_bs = 3'd7;
    bit             exp_frame = 1'b0;
    bit             req_hist[$];
    bit             prev_show = 1'b0;
    logic [11:0]    cur_data = '0;
    logic [EXP_W-1:0] exp_q[$];

    always @(posedge clock or negedge reset) begin
        bit         show;
        bit         phase;
        logic [3:0] seg;
        if (!reset) begin
            en_cycles   = 0;
            frames_seen = 0;
            exp_bs      = 3'd7;
            exp_frame   = 1'b0;
            req_hist.delete();
            prev_show   = 1'b0;
            cur_data    = '0;
            exp_q.delete();
        end else if (!enable) begin
            en_cycles = 0;
            exp_bs    = 3'd7;
            exp_frame = 1'b0;
        end else begin
            en_cycles++;
            exp_frame = 1'b0;
            if (en_cycles % SD == 0) begin
                exp_bs = 3'((7 + en_cycles / SD) % 8);
                if (exp_bs == 3'd0) begin
                    frames_seen++;
                    req_hist.push_back(ovl_req);
                    if (req_hist.size() > OH) void'(req_hist.pop_front());
                    show = 1'b0;
                    foreach (req_hist[i]) if (req_hist[i]) show = 1'b1;
                    phase    = ((frames_seen / BD) % 2) == 1;
                    seg      = digit_enable & ~(blink_mask & {4{phase}});
                    cur_data = show ? ovl_data : time_data;
                    exp_q.push_back({show && !prev_show, show, seg, cur_data});
                    prev_show = show;
                    exp_frame = 1'b1;
                end
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        logic [EXP_W-1:0] got;
        logic [EXP_W-1:0] exp;
        if (reset) begin
            check("frame_tick", 32'(frame_tick), 32'(exp_frame));
            check("byte_status", 32'(byte_status), 32'(exp_bs));
            if (frame_tick === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL frame_output: got frame_tick=1 expected no boundary at %0t", $time);
                end else begin
                    got = {ovl_ack, ovl_active, segment_byte_control, data_show};
                    exp = exp_q.pop_front();
                    check("frame_output", 32'(got), 32'(exp));
                end
            end else begin
                check("ovl_ack_idle", 32'(ovl_ack), 32'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_frame(input string name);
        bit found = 1'b0;
        for (int n = 0; n < 400 && !found; n++) begin
            @(negedge clock);
            found = (frame_tick === 1'b1);
        end
        check(name, 32'(found), 32'd1);
    endtask

    task automatic wait_bs(input logic [2:0] v, input string name);
        bit found = 1'b0;
        for (int n = 0; n < 400 && !found; n++) begin
            @(negedge clock);
            found = (byte_status === v);
        end
        check(name, 32'(found), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_data_show"}, 32'(data_show), 32'd0);
        check({tag, "_byte_status"}, 32'(byte_status), 32'd7);
        check({tag, "_seg_ctrl"}, 32'(segment_byte_control), 32'd0);
        check({tag, "_frame_tick"}, 32'(frame_tick), 32'd0);
        check({tag, "_ovl_ack"}, 32'(ovl_ack), 32'd0);
        check({tag, "_ovl_active"}, 32'(ovl_active), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] s[4];
        int         gap;

        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_values("reset");
        reset  = 1'b1;
        enable = 1'b1;

        // Scan cadence: 7 for three clocks, 0 with frame_tick on the fourth.
        repeat (3) @(negedge clock);
        check("scan_pre_step", 32'(byte_status), 32'd7);
        @(negedge clock);
        check("scan_first_frame_bs", 32'(byte_status), 32'd0);
        check("scan_first_frame_tick", 32'(frame_tick), 32'd1);
        repeat (4) @(negedge clock);
        check("scan_slot1", 32'(byte_status), 32'd1);
        gap = 4;
        for (int n = 0; n < 100; n++) begin
            @(negedge clock);
            gap++;
            if (frame_tick === 1'b1) break;
        end
        check("frame_period", 32'(gap), 32'd32);

        // Mid-frame time change must not tear.
        wait_bs(3'd3, "wait_bs3_tear");
        check("tear_before", 32'(data_show), 32'd0);
        time_data = 12'h2CB;
        @(negedge clock);
        check("tear_mid", 32'(data_show), 32'd0);
        wait_frame("wait_tear_frame");
        check("tear_after", 32'(data_show), 32'h2CB);

        // Overlay grant and hold-off.
        ovl_req  = 1'b1;
        ovl_data = 12'h105;
        wait_frame("wait_ovl_grant");
        check("ovl_ack_pulse", 32'(ovl_ack), 32'd1);
        check("ovl_active_on", 32'(ovl_active), 32'd1);
        check("ovl_data_shown", 32'(data_show), 32'h105);
        ovl_req = 1'b0;
        @(negedge clock);
        check("ovl_ack_single", 32'(ovl_ack), 32'd0);
        wait_frame("wait_hold1");
        check("hold1_active", 32'(ovl_active), 32'd1);
        wait_frame("wait_hold2");
        check("hold2_data", 32'(data_show), 32'h105);
        wait_frame("wait_hold3");
        check("hold3_active", 32'(ovl_active), 32'd0);
        check("hold3_data", 32'(data_show), 32'h2CB);

        // Blinking of digits 0 and 1.
        digit_enable = 4'hF;
        blink_mask   = 4'b0011;
        for (int j = 0; j < 4; j++) begin
            wait_frame("wait_blink");
            s[j] = segment_byte_control;
            check("blink_value", 32'((s[j] == 4'hF) || (s[j] == 4'hC)), 32'd1);
        end
        check("blink_alt0", 32'(s[0] != s[2]), 32'd1);
        check("blink_alt1", 32'(s[1] != s[3]), 32'd1);

        // Randomised traffic, including short blanking windows.
        for (int it = 0; it < 70; it++) begin
            repeat ($urandom_range(1, 60)) @(negedge clock);
            time_data    = 12'($urandom);
            ovl_data     = 12'($urandom);
            ovl_req      = ($urandom_range(0, 3) == 0);
            blink_mask   = 4'($urandom);
            digit_enable = 4'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                enable = 1'b0;
                repeat ($urandom_range(1, 20)) @(negedge clock);
                enable = 1'b1;
            end
        end

        // Blanking at slot 3 and re-enable.
        wait_bs(3'd3, "wait_bs3_blank");
        enable = 1'b0;
        @(negedge clock);
        check("blank_bs", 32'(byte_status), 32'd7);
        check("blank_no_tick", 32'(frame_tick), 32'd0);
        repeat (3) @(negedge clock);
        enable = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("reenable_wait_tick", 32'(frame_tick), 32'd0);
        end
        @(negedge clock);
        check("reenable_tick", 32'(frame_tick), 32'd1);
        check("reenable_bs", 32'(byte_status), 32'd0);

        // Asynchronous reset while the overlay is active.
        ovl_req = 1'b1;
        wait_frame("wait_ovl_before_reset");
        wait_bs(3'd3, "wait_bs3_reset");
        check("pre_reset_active", 32'(ovl_active), 32'd1);
        @(posedge clock);
        #1 reset = 1'b0;
        #1 check_reset_values("async");
        @(negedge clock);
        ovl_req = 1'b0;
        reset   = 1'b1;
        wait_frame("wait_post_reset1");
        wait_frame("wait_post_reset2");
        repeat (10) @(negedge clock);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
